// File: rtl/axi_wbuf_pkg.sv
// Shared types and constants for the AXI write buffer.
package axi_wbuf_pkg;

    localparam int AXI_LEN_WIDTH = 8;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        ISSUE,
        DRAIN,
        STREAM,
        RESP
    } wbuf_state_t;

    // True when a burst of (len+1) beats fits completely in the local FIFO.
    function automatic logic fits_in_fifo(input logic [AXI_LEN_WIDTH-1:0] len, input int depth);
        return (int'(len) + 1) <= depth;
    endfunction

endpackage

// File: rtl/axi_wbuf_fifo.sv
// Single-clock W-data FIFO. Pointers carry an extra wrap bit so full and
// empty can be told apart; the storage array itself is not reset.
module axi_wbuf_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic                  full,
    output logic                  empty,
    output logic [DATA_WIDTH-1:0] head
);

    localparam int PW = $clog2(DEPTH);

    logic [PW:0]           wr_ptr;
    logic [PW:0]           rd_ptr;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  do_push;
    logic                  do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign empty = (wr_ptr == rd_ptr);
    assign head  = mem[rd_ptr[PW-1:0]];

    // Pointer advance; a push into a full FIFO or a pop from an empty one is dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + {{PW{1'b0}}, 1'b1};
            if (do_pop)  rd_ptr <= rd_ptr + {{PW{1'b0}}, 1'b1};
        end
    end

    // Storage write.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[PW-1:0]] <= push_data;
    end

endmodule

// File: rtl/axi_write_buffer.sv
// Store-and-forward AXI write-channel buffer with cut-through fallback for
// bursts longer than the FIFO. Optional build macro AXI_WBUF_LAST_CHECK_EN
// enables the sticky s_wlast consistency flag (wlast_err).
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for an upstream AW; only s_awready is high
// FILL   | collecting all W beats of a burst that fits in the FIFO
// ISSUE  | presenting the buffered burst's AW downstream
// DRAIN  | replaying buffered beats downstream, wlast from out_cnt
// STREAM | long burst: AW issued at once, push and pop run together
// RESP   | relaying the single B handshake between the two sides
module axi_write_buffer
    import axi_wbuf_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [ADDR_WIDTH-1:0]    s_awaddr,
    input  logic [AXI_LEN_WIDTH-1:0] s_awlen,
    input  logic                     s_awvalid,
    output logic                     s_awready,
    input  logic [DATA_WIDTH-1:0]    s_wdata,
    input  logic                     s_wlast,
    input  logic                     s_wvalid,
    output logic                     s_wready,
    output logic                     s_bvalid,
    input  logic                     s_bready,
    output logic [ADDR_WIDTH-1:0]    m_awaddr,
    output logic [AXI_LEN_WIDTH-1:0] m_awlen,
    output logic                     m_awvalid,
    input  logic                     m_awready,
    output logic [DATA_WIDTH-1:0]    m_wdata,
    output logic                     m_wlast,
    output logic                     m_wvalid,
    input  logic                     m_wready,
    input  logic                     m_bvalid,
    output logic                     m_bready,
    output logic                     wlast_err
);

    wbuf_state_t              state_q;
    wbuf_state_t              state_d;
    logic [ADDR_WIDTH-1:0]    addr_q;
    logic [AXI_LEN_WIDTH-1:0] len_q;
    logic [AXI_LEN_WIDTH-1:0] in_cnt;
    logic [AXI_LEN_WIDTH-1:0] out_cnt;
    logic                     in_done;
    logic                     out_done;
    logic                     aw_done;
    logic                     push;
    logic                     pop;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic                     in_last;
    logic                     out_last;

    // in_done/out_done guard against the 8-bit counters wrapping on awlen=255.
    assign in_last  = (in_cnt == len_q);
    assign out_last = (out_cnt == len_q);
    assign m_awaddr = addr_q;
    assign m_awlen  = len_q;

    axi_wbuf_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (s_wdata),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (m_wdata)
    );

    // Next-state and handshake outputs.
    always_comb begin
        state_d   = state_q;
        s_awready = 1'b0;
        s_wready  = 1'b0;
        s_bvalid  = 1'b0;
        m_awvalid = 1'b0;
        m_wvalid  = 1'b0;
        m_wlast   = 1'b0;
        m_bready  = 1'b0;
        push      = 1'b0;
        pop       = 1'b0;
        unique case (state_q)
            IDLE: begin
                s_awready = 1'b1;
                if (s_awvalid) state_d = fits_in_fifo(s_awlen, DEPTH) ? FILL : STREAM;
            end
            FILL: begin
                s_wready = !fifo_full;
                push     = s_wvalid && s_wready;
                if (push && in_last) state_d = ISSUE;
            end
            ISSUE: begin
                m_awvalid = 1'b1;
                if (m_awready) state_d = DRAIN;
            end
            DRAIN: begin
                m_wvalid = !fifo_empty;
                m_wlast  = out_last;
                pop      = m_wvalid && m_wready;
                if (pop && out_last) state_d = RESP;
            end
            STREAM: begin
                m_awvalid = !aw_done;
                s_wready  = !fifo_full && !in_done;
                push      = s_wvalid && s_wready;
                m_wvalid  = !fifo_empty;
                m_wlast   = out_last;
                pop       = m_wvalid && m_wready;
                // AW must not be withdrawn, so a burst whose data beat AW out waits for it.
                if ((aw_done || m_awready) && (out_done || (pop && out_last))) state_d = RESP;
            end
            RESP: begin
                s_bvalid = m_bvalid;
                m_bready = s_bready;
                if (m_bvalid && s_bready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register, burst attributes and beat bookkeeping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            len_q    <= '0;
            in_cnt   <= '0;
            out_cnt  <= '0;
            in_done  <= 1'b0;
            out_done <= 1'b0;
            aw_done  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && s_awvalid) begin
                addr_q   <= s_awaddr;
                len_q    <= s_awlen;
                in_cnt   <= '0;
                out_cnt  <= '0;
                in_done  <= 1'b0;
                out_done <= 1'b0;
                aw_done  <= 1'b0;
            end else begin
                if (push) begin
                    in_cnt <= in_cnt + 8'd1;
                    if (in_last) in_done <= 1'b1;
                end
                if (pop) begin
                    out_cnt <= out_cnt + 8'd1;
                    if (out_last) out_done <= 1'b1;
                end
                if (m_awvalid && m_awready) aw_done <= 1'b1;
            end
        end
    end

`ifdef AXI_WBUF_LAST_CHECK_EN
    logic wlast_err_q;

    // Sticky flag: an accepted beat whose s_wlast disagrees with the beat count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wlast_err_q <= 1'b0;
        end else if (push && (s_wlast != in_last)) begin
            wlast_err_q <= 1'b1;
        end
    end

    assign wlast_err = wlast_err_q;
`else
    logic unused_wlast;

    assign unused_wlast = s_wlast;
    assign wlast_err    = 1'b0;
`endif

endmodule

// File: tb/tb_axi_write_buffer.sv
`timescale 1ns/1ps
module tb_axi_write_buffer;

    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;
    localparam int DEPTH      = 16;
    localparam int TMO        = 3000;
`ifdef AXI_WBUF_LAST_CHECK_EN
    localparam bit EXP_ERR = 1'b1;
`else
    localparam bit EXP_ERR = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  reset;
    logic [ADDR_WIDTH-1:0] s_awaddr;
    logic [7:0]            s_awlen;
    logic                  s_awvalid;
    logic                  s_awready;
    logic [DATA_WIDTH-1:0] s_wdata;
    logic                  s_wlast;
    logic                  s_wvalid;
    logic                  s_wready;
    logic                  s_bvalid;
    logic                  s_bready;
    logic [ADDR_WIDTH-1:0] m_awaddr;
    logic [7:0]            m_awlen;
    logic                  m_awvalid;
    logic                  m_awready;
    logic [DATA_WIDTH-1:0] m_wdata;
    logic                  m_wlast;
    logic                  m_wvalid;
    logic                  m_wready;
    logic                  m_bvalid;
    logic                  m_bready;
    logic                  wlast_err;

    // downstream behaviour: 0 always ready, 1 wready toggling, 2 random, 3 manual
    logic [1:0] ds_mode = 2'd0;
    logic rnd_awready = 1'b0, rnd_wready = 1'b0, rnd_bvalid = 1'b0, rnd_bready = 1'b0;
    logic man_awready = 1'b0, man_wready = 1'b0, man_bvalid = 1'b0, man_bready = 1'b0;

    assign m_awready = (ds_mode == 2'd3) ? man_awready : rnd_awready;
    assign m_wready  = (ds_mode == 2'd3) ? man_wready  : rnd_wready;
    assign m_bvalid  = (ds_mode == 2'd3) ? man_bvalid  : rnd_bvalid;
    assign s_bready  = (ds_mode == 2'd3) ? man_bready  : rnd_bready;

    always #5 clk = ~clk;

    axi_write_buffer #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .s_awaddr  (s_awaddr),
        .s_awlen   (s_awlen),
        .s_awvalid (s_awvalid),
        .s_awready (s_awready),
        .s_wdata   (s_wdata),
        .s_wlast   (s_wlast),
        .s_wvalid  (s_wvalid),
        .s_wready  (s_wready),
        .s_bvalid  (s_bvalid),
        .s_bready  (s_bready),
        .m_awaddr  (m_awaddr),
        .m_awlen   (m_awlen),
        .m_awvalid (m_awvalid),
        .m_awready (m_awready),
        .m_wdata   (m_wdata),
        .m_wlast   (m_wlast),
        .m_wvalid  (m_wvalid),
        .m_wready  (m_wready),
        .m_bvalid  (m_bvalid),
        .m_bready  (m_bready),
        .wlast_err (wlast_err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model (transaction level) ----------------
    bit                    m_busy = 1'b0;
    bit                    m_stream = 1'b0;
    bit                    m_aw_done = 1'b0;
    bit                    m_err = 1'b0;
    int                    m_beats = 0;
    int                    m_acc = 0;
    int                    m_pop = 0;
    logic [ADDR_WIDTH-1:0] m_addr = '0;
    logic [7:0]            m_len = '0;
    logic [DATA_WIDTH-1:0] exp_q[$];
    logic [DATA_WIDTH-1:0] log_d[$];
    bit                    log_l[$];

    // Compare on the falling edge, then advance the model by the handshakes
    // that the coming rising edge will perform (inputs are stable until then).
    always @(negedge clk) begin
        bit e_resp, e_awrdy, e_wrdy, e_awv, e_wv, e_bv, e_mbr;
        if (reset) begin
            m_busy = 1'b0; m_err = 1'b0; m_acc = 0; m_pop = 0; m_aw_done = 1'b0;
            exp_q.delete();
            chk("rst_s_awready", s_awready, 1'b1);
            chk("rst_s_wready",  s_wready,  1'b0);
            chk("rst_m_awvalid", m_awvalid, 1'b0);
            chk("rst_m_wvalid",  m_wvalid,  1'b0);
            chk("rst_s_bvalid",  s_bvalid,  1'b0);
            chk("rst_m_bready",  m_bready,  1'b0);
            chk("rst_wlast_err", wlast_err, 1'b0);
        end else begin
            e_resp  = m_busy && (m_pop == m_beats) && m_aw_done;
            e_awrdy = !m_busy;
            e_wrdy  = m_busy && (m_acc < m_beats) && (exp_q.size() < DEPTH);
            e_awv   = m_busy && !m_aw_done && (m_stream || (m_acc == m_beats));
            e_wv    = m_busy && (exp_q.size() > 0) && (m_stream || m_aw_done);
            e_bv    = e_resp && m_bvalid;
            e_mbr   = e_resp && s_bready;
            chk("s_awready", s_awready, e_awrdy);
            chk("s_wready",  s_wready,  e_wrdy);
            chk("m_awvalid", m_awvalid, e_awv);
            chk("m_wvalid",  m_wvalid,  e_wv);
            chk("s_bvalid",  s_bvalid,  e_bv);
            chk("m_bready",  m_bready,  e_mbr);
            chk("wlast_err", wlast_err, m_err);
            if (e_awv) begin
                chk("m_awaddr", m_awaddr, m_addr);
                chk("m_awlen",  m_awlen,  m_len);
            end
            if (e_wv) begin
                chk("m_wdata", m_wdata, exp_q[0]);
                chk("m_wlast", m_wlast, m_pop == int'(m_len));
            end
            if (e_awrdy && s_awvalid) begin
                m_busy = 1'b1; m_addr = s_awaddr; m_len = s_awlen;
                m_beats = int'(s_awlen) + 1; m_stream = (m_beats > DEPTH);
                m_acc = 0; m_pop = 0; m_aw_done = 1'b0;
                exp_q.delete();
            end else begin
                if (e_awv && m_awready) m_aw_done = 1'b1;
                if (e_wv && m_wready) begin
                    log_d.push_back(m_wdata);
                    log_l.push_back(m_wlast);
                    void'(exp_q.pop_front());
                    m_pop++;
                end
                if (e_wrdy && s_wvalid) begin
`ifdef AXI_WBUF_LAST_CHECK_EN
                    if (s_wlast != (m_acc == int'(m_len))) m_err = 1'b1;
`endif
                    exp_q.push_back(s_wdata);
                    m_acc++;
                end
                if (e_bv && s_bready) m_busy = 1'b0;
            end
        end
    end

    // Downstream responder for the non-manual modes.
    always @(posedge clk) begin
        #1;
        case (ds_mode)
            2'd0: begin
                rnd_awready = 1'b1; rnd_wready = 1'b1; rnd_bvalid = 1'b1; rnd_bready = 1'b1;
            end
            2'd1: begin
                rnd_awready = 1'b1; rnd_wready = ~rnd_wready; rnd_bvalid = 1'b1; rnd_bready = 1'b1;
            end
            default: begin
                rnd_awready = ($urandom_range(0, 3) != 0);
                rnd_wready  = 1'($urandom_range(0, 1));
                rnd_bvalid  = 1'($urandom_range(0, 1));
                rnd_bready  = 1'($urandom_range(0, 1));
            end
        endcase
    end

    // ---------------- upstream driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_aw(input logic [ADDR_WIDTH-1:0] addr, input logic [7:0] len);
        int n = 0;
        s_awaddr = addr; s_awlen = len; s_awvalid = 1'b1;
        while (!s_awready && n < TMO) begin tick(); n++; end
        if (n >= TMO) chk("aw_timeout", 1'b1, 1'b0);
        tick();
        s_awvalid = 1'b0;
    endtask

    task automatic put_beat(input logic [DATA_WIDTH-1:0] d, input logic last);
        int n = 0;
        s_wdata = d; s_wlast = last; s_wvalid = 1'b1;
        while (!s_wready && n < TMO) begin tick(); n++; end
        if (n >= TMO) chk("w_timeout", 1'b1, 1'b0);
        tick();
        s_wvalid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!s_awready && n < TMO) begin tick(); n++; end
        if (n >= TMO) chk("idle_timeout", 1'b1, 1'b0);
    endtask

    task automatic check_log(input string nm, input logic [DATA_WIDTH-1:0] base, input int beats);
        chk({nm, "_count"}, log_d.size(), beats);
        for (int i = 0; i < beats && i < log_d.size(); i++) begin
            chk({nm, "_data"}, log_d[i], base + DATA_WIDTH'(i));
            chk({nm, "_last"}, log_l[i], i == beats - 1);
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: actual running required finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        logic [7:0] len;
        reset = 1'b0; s_awaddr = '0; s_awlen = '0; s_awvalid = 1'b0;
        s_wdata = '0; s_wlast = 1'b0; s_wvalid = 1'b0;
        #2 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // 1: store-and-forward, everything ready
        ds_mode = 2'd0;
        log_d.delete(); log_l.delete();
        send_aw(32'h100, 8'd3);
        for (int i = 0; i < 4; i++) put_beat(32'hA0 + 32'(i), i == 3);
        chk("t1_awvalid_after_last", m_awvalid, 1'b1);
        chk("t1_awaddr", m_awaddr, 32'h100);
        wait_idle();
        check_log("t1", 32'hA0, 4);

        // 2: same burst, downstream wready toggling
        ds_mode = 2'd1;
        log_d.delete(); log_l.delete();
        send_aw(32'h100, 8'd3);
        for (int i = 0; i < 4; i++) put_beat(32'hA0 + 32'(i), i == 3);
        wait_idle();
        check_log("t2", 32'hA0, 4);

        // 3: long burst goes cut-through and fills the FIFO
        log_d.delete(); log_l.delete();
        send_aw(32'h2000, 8'd31);
        chk("t3_stream_aw", m_awvalid, 1'b1);
        for (int i = 0; i < 32; i++) put_beat(32'h1000 + 32'(i), i == 31);
        wait_idle();
        check_log("t3", 32'h1000, 32);

        // 4: B held by the upstream side
        ds_mode = 2'd3;
        man_awready = 1'b1; man_wready = 1'b1; man_bvalid = 1'b0; man_bready = 1'b0;
        send_aw(32'h300, 8'd0);
        put_beat(32'h55, 1'b1);
        n = 0;
        while (!(m_busy && m_pop == m_beats && m_aw_done) && n < TMO) begin tick(); n++; end
        if (n >= TMO) chk("t4_resp_timeout", 1'b1, 1'b0);
        man_bvalid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t4_s_bvalid", s_bvalid, 1'b1);
            chk("t4_m_bready", m_bready, 1'b0);
            chk("t4_s_awready", s_awready, 1'b0);
            tick();
        end
        man_bready = 1'b1;
        @(negedge clk);
        chk("t4_m_bready_hs", m_bready, 1'b1);
        tick();
        chk("t4_idle_after_b", s_awready, 1'b1);
        man_bvalid = 1'b0; man_bready = 1'b0;

        // 5: reset in the middle of a burst
        ds_mode = 2'd0;
        send_aw(32'h400, 8'd7);
        put_beat(32'hB0, 1'b0);
        put_beat(32'hB1, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        chk("t5_s_awready", s_awready, 1'b1);
        chk("t5_m_awvalid", m_awvalid, 1'b0);
        chk("t5_m_wvalid", m_wvalid, 1'b0);
        chk("t5_s_bvalid", s_bvalid, 1'b0);
        chk("t5_fifo_empty", dut.u_fifo.empty, 1'b1);
        tick();
        reset = 1'b0;
        log_d.delete(); log_l.delete();
        send_aw(32'h480, 8'd7);
        for (int i = 0; i < 8; i++) put_beat(32'hC0 + 32'(i), i == 7);
        wait_idle();
        check_log("t5", 32'hC0, 8);

        // 6: early s_wlast on beat 1
        log_d.delete(); log_l.delete();
        send_aw(32'h600, 8'd3);
        for (int i = 0; i < 4; i++) put_beat(32'hD0 + 32'(i), (i == 1) || (i == 3));
        wait_idle();
        chk("t6_wlast_err", wlast_err, EXP_ERR);
        check_log("t6", 32'hD0, 4);
        send_aw(32'h640, 8'd1);
        put_beat(32'hE0, 1'b0);
        put_beat(32'hE1, 1'b1);
        wait_idle();
        chk("t6_wlast_err_sticky", wlast_err, EXP_ERR);

        // 7: randomized bursts against the model
        ds_mode = 2'd2;
        for (int b = 0; b < 41; b++) begin
            case ($urandom_range(0, 9))
                0:       len = 8'd0;
                1:       len = 8'd15;
                2:       len = 8'd16;
                3, 4:    len = 8'($urandom_range(17, 40));
                default: len = 8'($urandom_range(1, 14));
            endcase
            if (b == 40) len = 8'd255;
            repeat ($urandom_range(0, 2)) tick();
            send_aw($urandom(), len);
            for (int i = 0; i <= int'(len); i++) begin
                repeat ($urandom_range(0, 2)) tick();
                put_beat($urandom(), i == int'(len));
            end
            if ($urandom_range(0, 3) == 0) begin
                s_wdata = $urandom(); s_wlast = 1'b0; s_wvalid = 1'b1;
                repeat (2) tick();
                s_wvalid = 1'b0;
            end
        end
        wait_idle();
        repeat (4) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
